// File: rtl/arduino_rsa_pkg.sv
// Shared types and constants for the Arduino-to-RSA-core bus controller.
package arduino_rsa_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] CMD_MODEXP = 32'h0000_00A5;
  localparam logic [31:0] ERR_WORD   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_M = 3'd1,
    ST_LOAD_E = 3'd2,
    ST_LOAD_N = 3'd3,
    ST_START  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

endpackage

// File: rtl/arduino_rsa_ctrl_strobe_sync.sv
// Multi-flop synchroniser for an asynchronous strobe, with a rising-edge pulse
// derived from the synchronised level.
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/arduino_rsa_ctrl.sv
// Arduino parallel-bus front end for the RSA mod-exp core: command + three operands in,
// result out. Define ARD_CORE_TIMEOUT_EN to add a core-wait timeout leading to ERROR.
module arduino_rsa_ctrl
  import arduino_rsa_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ard_write,
  input  logic              ard_oe,
  input  logic [DATA_W-1:0] ard_data_in,
  output logic [DATA_W-1:0] ard_data_out,
  output logic              ard_data_oe,
  output logic [DATA_W-1:0] core_msg,
  output logic [DATA_W-1:0] core_exp,
  output logic [DATA_W-1:0] core_mod,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              busy,
  output logic              error,
  output logic [2:0]        state_led
);

  state_t            state_q, state_d;
  logic              wr_level, wr_evt, oe_level, oe_rise;
  logic              is_cmd, timeout;
  logic [DATA_W-1:0] msg_q, exp_q, mod_q, result_q, data_out_q;
  logic              data_oe_q;
  logic              unused;

  // Bus handshake: the Arduino has no back-pressure. A word is accepted once, on the
  // synchronised rising edge of ard_write, and ard_data_in is sampled in that cycle only.
  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rstn(rstn), .async_in(ard_write), .level(wr_level), .rise(wr_evt)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_oe_sync (
    .clk(clk), .rstn(rstn), .async_in(ard_oe), .level(oe_level), .rise(oe_rise)
  );

  assign unused = wr_level ^ oe_rise;
  assign is_cmd = (ard_data_in == DATA_W'(CMD_MODEXP));

`ifdef ARD_CORE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_START) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_WAIT && to_cnt_q != '1) begin
      to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
    end
  end

  // Leave WAIT on the cycle the counter steps onto all-ones.
  assign timeout = (to_cnt_q == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
  assign error   = (state_q == ST_ERROR);
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (wr_evt && is_cmd) state_d = ST_LOAD_M;
      ST_LOAD_M: if (wr_evt) state_d = ST_LOAD_E;
      ST_LOAD_E: if (wr_evt) state_d = ST_LOAD_N;
      ST_LOAD_N: if (wr_evt) state_d = ST_START;
      ST_START:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done)    state_d = ST_DONE;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_DONE, ST_ERROR: if (wr_evt) state_d = is_cmd ? ST_LOAD_M : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msg_q      <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      result_q   <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      if (wr_evt && state_q == ST_LOAD_M) msg_q <= ard_data_in;
      if (wr_evt && state_q == ST_LOAD_E) exp_q <= ard_data_in;
      if (wr_evt && state_q == ST_LOAD_N) mod_q <= ard_data_in;
      if (core_done && state_q == ST_WAIT) result_q <= core_result;
      // The extra register stage gives SYNC_STAGES+1 clocks from oe to pad enable.
      data_oe_q <= oe_level;
      case (state_q)
        ST_DONE:  data_out_q <= result_q;
        ST_ERROR: data_out_q <= DATA_W'(ERR_WORD);
        default:  data_out_q <= {{(DATA_W-3){1'b0}}, state_q};
      endcase
    end
  end

  assign core_msg     = msg_q;
  assign core_exp     = exp_q;
  assign core_mod     = mod_q;
  assign core_start   = (state_q == ST_START);
  assign busy         = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign state_led    = state_q;
  assign ard_data_out = data_out_q;
  assign ard_data_oe  = data_oe_q;

endmodule

// File: tb/tb_arduino_rsa_ctrl.sv
// Self-checking bench for arduino_rsa_ctrl: random jobs against a behavioural bus/job model.
module tb_arduino_rsa_ctrl;

  localparam int W    = 32;
  localparam int SYNC = 2;
`ifdef ARD_CORE_TIMEOUT_EN
  localparam int TO_W = 8;
`else
  localparam int TO_W = 24;
`endif
  localparam logic [31:0] CMD = 32'h0000_00A5;

  logic         clk, rstn, ard_write, ard_oe, core_done, core_start, busy, error, ard_data_oe;
  logic [W-1:0] ard_data_in, ard_data_out, core_msg, core_exp, core_mod, core_result;
  logic [2:0]   state_led;

  arduino_rsa_ctrl #(.DATA_W(W), .SYNC_STAGES(SYNC), .TIMEOUT_W(TO_W)) dut (
    .clk(clk), .rstn(rstn), .ard_write(ard_write), .ard_oe(ard_oe),
    .ard_data_in(ard_data_in), .ard_data_out(ard_data_out), .ard_data_oe(ard_data_oe),
    .core_msg(core_msg), .core_exp(core_exp), .core_mod(core_mod),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .busy(busy), .error(error), .state_led(state_led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model of the controller as seen from the bus
  int           model_st = 0;
  logic [W-1:0] m_msg = '0, m_exp = '0, m_mod = '0;

  // core model
  int           countdown = -1;
  int           done_delay = 50;
  bit           hold_done = 1'b0;
  logic [W-1:0] next_result = '0;
  int           start_cnt = 0;
  int           wait_cycles = 0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (!rstn) begin
      countdown = -1;
    end else if (core_start) begin
      start_cnt++;
      wait_cycles = 0;
      countdown = hold_done ? -1 : done_delay;
    end else begin
      if (state_led == 3'd5) wait_cycles++;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          core_done   = 1'b1;
          core_result = next_result;
          countdown   = -1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic write_word(input logic [W-1:0] w);
    @(negedge clk);
    ard_data_in = w;
    ard_write   = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    ard_write = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_ops(input string tag);
    chk({tag, "_msg"}, core_msg, m_msg);
    chk({tag, "_exp"}, core_exp, m_exp);
    chk({tag, "_mod"}, core_mod, m_mod);
  endtask

  // One bus write, applied to the model (LOAD_N leads through START into WAIT).
  task automatic send(input logic [W-1:0] w);
    write_word(w);
    case (model_st)
      0: if (w == CMD) model_st = 1;
      1: begin m_msg = w; model_st = 2; end
      2: begin m_exp = w; model_st = 3; end
      3: begin m_mod = w; model_st = 5; end
      6, 7: model_st = (w == CMD) ? 1 : 0;
      default: ;
    endcase
    chk("state", {29'b0, state_led}, model_st);
    check_ops("ops");
  endtask

  task automatic read_check(input string tag, input logic [W-1:0] exp);
    @(negedge clk);
    ard_oe = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk({tag, "_oe"}, {31'b0, ard_data_oe}, 1);
    chk(tag, ard_data_out, exp);
    ard_oe = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    chk({tag, "_oe_off"}, {31'b0, ard_data_oe}, 0);
  endtask

  task automatic wait_for_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (state_led !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {29'b0, state_led}, {29'b0, s});
  endtask

  task automatic run_job(input logic [W-1:0] msg, input logic [W-1:0] ex, input logic [W-1:0] md,
                         input logic [W-1:0] res, input int delay, input int n_extra,
                         input bit skip_cmd);
    int s0;
    next_result = res;
    done_delay  = delay;
    exp_q.push_back(res);
    if (!skip_cmd) send(CMD);
    send(msg);
    send(ex);
    s0 = start_cnt;
    send(md);
    chk("start_pulse", start_cnt, s0 + 1);
    chk("busy_wait", {31'b0, busy}, 1);
    for (int i = 0; i < n_extra; i++) send($urandom);
    wait_for_state("done", 3'd6, delay + 40);
    model_st = 6;
    chk("busy_done", {31'b0, busy}, 0);
    chk("start_once", start_cnt, s0 + 1);
    check_ops("ops_done");
    read_check("result", exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    rstn = 1'b0; ard_write = 1'b0; ard_oe = 1'b0; ard_data_in = '0; core_done = 1'b0;
    core_result = '0;
    repeat (4) @(negedge clk);
    chk("rst_data_out", ard_data_out, 0);
    chk("rst_data_oe", {31'b0, ard_data_oe}, 0);
    chk("rst_start", {31'b0, core_start}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_state", {29'b0, state_led}, 0);
    check_ops("rst");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // bad commands in IDLE
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 32'h0000_0011 : $urandom;
      if (w == CMD) w = w ^ 32'h1;
      send(w);
    end
    read_check("status_idle", 32'h0);

    // oe-to-pad-enable latency
    @(negedge clk);
    ard_oe = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk("oe_latency_early", {31'b0, ard_data_oe}, 0);
    @(negedge clk);
    chk("oe_latency", {31'b0, ard_data_oe}, 1);
    ard_oe = 1'b0;
    repeat (SYNC + 2) @(negedge clk);

    // reference job
    run_job(32'h0321_78C4, 32'h0000_0011, 32'h07A5_0679, 32'h1234_ABCD, 50, 0, 1'b0);

    // back-to-back random jobs, some with writes during WAIT, some returning to IDLE
    for (int j = 0; j < 6; j++) begin
      int extra;
      extra = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom;
        if (w == CMD) w = 32'h0;
        send(w);
      end
      run_job($urandom, $urandom, $urandom, $urandom,
              (extra > 0) ? $urandom_range(45, 80) : $urandom_range(20, 60), extra, 1'b0);
    end

    // status word read while loading, then reset mid-load
    send(CMD);
    send($urandom);
    read_check("status_load_e", 32'h2);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    model_st = 0; m_msg = '0; m_exp = '0; m_mod = '0;
    chk("midrst_state", {29'b0, state_led}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_start", {31'b0, core_start}, 0);
    chk("midrst_data_out", ard_data_out, 0);
    check_ops("midrst");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    run_job($urandom, $urandom, $urandom, $urandom, 30, 0, 1'b0);

`ifdef ARD_CORE_TIMEOUT_EN
    hold_done = 1'b1;
    send(CMD);
    send($urandom);
    send($urandom);
    send($urandom);
    wait_for_state("timeout", 3'd7, (2 ** TO_W) + 40);
    model_st = 7;
    chk("timeout_cycles", wait_cycles, (2 ** TO_W) - 1);
    chk("timeout_error", {31'b0, error}, 1);
    chk("timeout_busy", {31'b0, busy}, 0);
    read_check("err_word", 32'hFFFF_FFFF);
    hold_done = 1'b0;
    send(CMD);
    chk("error_cleared", {31'b0, error}, 0);
    run_job($urandom, $urandom, $urandom, $urandom, 25, 0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arduino_rsa_ctrl.md
Name: arduino_rsa_ctrl

Overview:
- Clocked controller between the Arduino parallel bus and the RSA modular-exponentiation core.
- Synchronises the Arduino write/oe strobes and receives a command word followed by three operands (message, exponent, modulus).
- Pulses the core start, waits for done, then presents the result on the bus read path.
- Replaces direct strobe-clocked capture with a single-clock-domain FSM. The top level owns the inout pad.

Parameters:
- DATA_W, 32, bus and operand width.
- SYNC_STAGES, 2, flip-flop stages on each Arduino strobe; minimum 2.
- TIMEOUT_W, 24, width of the core-wait timeout counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- ard_write  in  1  Arduino write strobe; asynchronous; rising edge means a word is valid.
- ard_oe  in  1  Arduino read request; asynchronous; level.
- ard_data_in  in  DATA_W  bus input from pad.
- ard_data_out  out  DATA_W  bus output to pad.
- ard_data_oe  out  1  pad tri-state enable.
- core_msg  out  DATA_W  message operand.
- core_exp  out  DATA_W  exponent operand.
- core_mod  out  DATA_W  modulus operand.
- core_start  out  1  single-cycle start pulse.
- core_done  in  1  core completion; level or pulse; sampled in WAIT only.
- core_result  in  DATA_W  valid while core_done is high.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- error  out  1  high in the ERROR state.
- state_led  out  3  current state encoding.

Behaviour:
- Reset values: all outputs 0; operand and result registers 0; FSM in IDLE.
- Strobes: each strobe passes through SYNC_STAGES flip-flops. A rising-edge detect on synced write gives wr_evt, a one-cycle pulse.
- Data sampling: ard_data_in is sampled in the cycle wr_evt is high. The Arduino holds data stable for at least SYNC_STAGES+2 clocks after raising write. ard_data_in is not synchronised.
- States and transitions:
  - IDLE(0): on wr_evt, if data == CMD_MODEXP (32'h0000_00A5) go to LOAD_M. Any other word is ignored and the FSM stays in IDLE.
  - LOAD_M(1): on wr_evt, core_msg <= data; go to LOAD_E.
  - LOAD_E(2): on wr_evt, core_exp <= data; go to LOAD_N.
  - LOAD_N(3): on wr_evt, core_mod <= data; go to START.
  - START(4): core_start = 1 for exactly one cycle; operands stay frozen; go to WAIT.
  - WAIT(5): when core_done = 1, result_reg <= core_result and go to DONE. wr_evt is ignored.
  - DONE(6): result is available for read. wr_evt carrying CMD_MODEXP goes to LOAD_M (new job); any other wr_evt goes to IDLE.
  - ERROR(7): see Optional Feature. wr_evt handling is the same as in DONE.
- Operand registers change only in their LOAD state; they are stable from LOAD_N exit until the next LOAD_M entry.
- Read path:
  - ard_data_oe = synced oe, in any state.
  - ard_data_out = result_reg in DONE; ERR_WORD (32'hFFFF_FFFF) in ERROR; otherwise the status word {29'b0, state}.
  - Latency: SYNC_STAGES+1 clocks from the oe edge to the pad enable.
- Simultaneous events: wr_evt in the cycle core_done rises (WAIT) — done wins and the write is dropped.
- Reset mid-operation: immediate return to IDLE. core_start is deasserted and operands are cleared; the core is expected to share rstn.
- Widths: no arithmetic on data; the counter is TIMEOUT_W bits and saturates, never wraps.

Optional Feature:
- Macro ARD_CORE_TIMEOUT_EN.
- When defined: a TIMEOUT_W-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches all-ones without core_done, go to ERROR and assert error.
- When undefined: no counter; WAIT lasts until core_done; ERROR is unreachable and error is tied to 0.

Decomposition:
- Package arduino_rsa_pkg: state enum (3-bit, encodings above), CMD_MODEXP, ERR_WORD, DATA_W default.
- Sub-module strobe_sync: SYNC_STAGES synchroniser plus rising-edge detector; outputs sync level and pulse. Instantiated for write and for oe.

Test Plan:
- Full job: write 0xA5, then 0x032178C4, 0x00000011, 0x07A50679. Expect core_msg/core_exp/core_mod equal to those values, exactly one core_start pulse, busy = 1. Model core_done after 50 cycles with result 0x1234ABCD; raise oe; expect ard_data_out = 0x1234ABCD and ard_data_oe = 1.
- Bad command: write 0x00000011 in IDLE. Expect state stays 0, no operand change, status read = 0x00000000.
- Writes during WAIT: 3 extra writes before done. Expect operands unchanged, state 5, then DONE with the correct result.
- Back-to-back jobs: from DONE, write 0xA5 and a new operand set. Expect LOAD_M entry without passing IDLE and a second start pulse.
- Reset mid-load: assert rstn low in LOAD_E. Expect all outputs 0 and IDLE; after release, the next 0xA5 starts cleanly.
- Timeout (macro defined, TIMEOUT_W = 4): withhold core_done. Expect ERROR after 15 WAIT cycles, error = 1, read = 0xFFFFFFFF; then a write of 0xA5 gives LOAD_M with error = 0.
